rv_multicycle_ctrl_alu: RTL and testbench
=========================================

Name: rv_multicycle_ctrl_alu

Overview:
- Control and execute slice of the multicycle RV32I core.
- Contains three parts: a Moore control FSM (fetch/decode/execute sequencing), an ALU-operation decoder (aluop + funct3/funct7 → 4-bit op), and a 32-bit combinational ALU with zero flag.
- Drives every mux select and write enable of the datapath: PC, IR, register file, memory-address mux, ALU-input muxes.
- The core forms the PC load as pc_write | (zero & pc_write_cond).

Parameters:
- none

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- instruction_opcode  in  7  IR[6:0]
- func3  in  3  IR[14:12]
- func7  in  7  IR[31:25]
- alu_in_x  in  32  ALU operand A (from A-mux)
- alu_in_y  in  32  ALU operand B (from B-mux)
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero
- lord  out  1  memory address: 0=PC, 1=ALUOut register
- memory_read  out  1  memory read strobe
- memory_write  out  1  memory write strobe
- memory_to_reg  out  1  register write data: 0=ALUOut register, 1=memory data register
- ir_write  out  1  latch IR and pc_old
- pc_source  out  1  PC input: 0=ALU result (combinational), 1=ALUOut register
- alu_src_a  out  2  A-mux select: 00=PC, 01=rs1 register, 10=pc_old, 11=0
- alu_src_b  out  2  B-mux select: 00=rs2 register, 01=4, 10=immediate, 11=0
- reg_write  out  1  register-file write enable
- state  out  4  current FSM state (for debug/verification)
- alu_operation  out  4  decoded ALU op
- alu_result  out  32  ALU output
- zero  out  1  alu_result == 0

Behaviour:
- FSM updates on posedge clk. Reset sets state to FETCH(0). All outputs are combinational from state.
- While reset is high, pc_write, pc_write_cond, ir_write, reg_write, memory_read and memory_write are all forced to 0.
- Defaults in every state: all enables 0, selects 00, pc_source 0, internal aluop=00, is_immediate=0.
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, EXEC_I 7, ALU_WB 8, BRANCH 9, JAL 10, JALR 11, LUI 12.
- Per-state outputs and next state:
  - FETCH: memory_read=1, lord=0, ir_write=1, src_a=00, src_b=01, pc_write=1, pc_source=0 → DECODE.
  - DECODE: src_a=10, src_b=10 (computes branch/jump target pc_old+imm). Next state by opcode:
    - 0000011 or 0100011 → MEM_ADDR
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 → LUI
    - 0010111 (AUIPC) → ALU_WB
    - any other opcode → FETCH (executes as a NOP)
  - MEM_ADDR: src_a=01, src_b=10 → MEM_READ if opcode=0000011, else MEM_WRITE.
  - MEM_READ: memory_read=1, lord=1 → MEM_WB.
  - MEM_WB: reg_write=1, memory_to_reg=1 → FETCH.
  - MEM_WRITE: memory_write=1, lord=1 → FETCH.
  - EXEC_R: src_a=01, src_b=00, aluop=10 → ALU_WB.
  - EXEC_I: src_a=01, src_b=10, aluop=10, is_immediate=1 → ALU_WB.
  - ALU_WB: reg_write=1, memory_to_reg=0 → FETCH.
  - BRANCH: src_a=01, src_b=00, aluop=01, pc_write_cond=1, pc_source=1 → FETCH.
  - JALR: src_a=01, src_b=10 (rs1+imm) → JAL. Target LSB is not masked.
  - JAL: src_a=00, src_b=11 (link = PC, already pc_old+4), pc_write=1, pc_source=1 → ALU_WB.
  - LUI: src_a=11, src_b=10 → ALU_WB.
- ALU-operation decoder (aluop, func3, func7[5], is_immediate → alu_operation):
  - aluop 00 or 11 → ADD.
  - aluop 01 (branches; op chosen so result==0 means taken): func3 000→SUB, 001→SEQ, 100→SGE, 101→SLT, 110→SGEU, 111→SLTU; 010/011→SUB.
  - aluop 10:
    - func3 000 → SUB if !is_immediate && func7[5], else ADD
    - 001 → SLL
    - 010 → SLT
    - 011 → SLTU
    - 100 → XOR
    - 101 → SRA if func7[5], else SRL (applies to both immediate and register forms)
    - 110 → OR
    - 111 → AND
- ALU op codes and results:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB (add/sub wrap mod 2^32)
  - 0100 SLL, 0101 SRL, 0111 SRA (shift amount y[4:0])
  - 1000 SLT, 1001 SLTU, 1010 SGE, 1011 SGEU, 1100 SEQ (result 0 or 1; signed or unsigned as named)
  - 1101–1111 → result 0
- zero = (alu_result == 0), purely combinational.
- Cycle counts (reset release to back at FETCH):
  - load 5
  - store 4
  - R/I-type, LUI 4
  - AUIPC 3
  - branch 3
  - JAL 4
  - JALR 5
  - illegal opcode 2
- Reset asserted in any state → FETCH on the next edge; any in-flight instruction is abandoned.

Test Plan:
- Reset 2 cycles, opcode 0110011, func3 000, func7 0100000 → states 0,1,6,8,0. In EXEC_R: alu_operation=0110; x=5, y=7 → alu_result 0xFFFFFFFE, zero 0. ALU_WB: reg_write=1, memory_to_reg=0.
- Opcode 0000011 → states 0,1,2,3,4,0. MEM_READ: memory_read=1, lord=1. MEM_WB: reg_write=1, memory_to_reg=1.
- Opcode 0100011 → states 0,1,2,5,0. MEM_WRITE: memory_write=1, lord=1, reg_write=0.
- BRANCH with func3 100, x=0xFFFFFFFF, y=1 → alu_operation SGE, result 0, zero 1, pc_write_cond=1, pc_source=1. Same operands with func3 110 → result 1, zero 0. func3 000 with x=y=9 → zero 1.
- EXEC_I with func3 101, func7 0100000, x=0x80000000, y=4 → result 0xF8000000. func3 000 with func7 0100000 → ADD (0010), not SUB.
- JALR → states 1,11,10,8,0. JAL state: pc_write=1, pc_source=1, src_a=00, src_b=11.
- Reset asserted in MEM_READ → all enables 0 while reset high, state 0 after the edge.
- Opcode 0000000 → states 1→0 with no write enable asserted.

Source files
------------

// File: rtl/rv_multicycle_ctrl_alu_if.sv
// rv_multicycle_ctrl_alu_if: instruction fields and ALU operands in, datapath controls and ALU result out
// master: datapath side (drives IR fields and operands); slave: control/ALU slice
interface rv_multicycle_ctrl_alu_if;
  logic [6:0]  instruction_opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] alu_in_x;
  logic [31:0] alu_in_y;
  logic        pc_write;
  logic        pc_write_cond;
  logic        lord;
  logic        memory_read;
  logic        memory_write;
  logic        memory_to_reg;
  logic        ir_write;
  logic        pc_source;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic        reg_write;
  logic [3:0]  state;
  logic [3:0]  alu_operation;
  logic [31:0] alu_result;
  logic        zero;
  modport master (
    output instruction_opcode, func3, func7, alu_in_x, alu_in_y,
    input  pc_write, pc_write_cond, lord, memory_read, memory_write, memory_to_reg,
           ir_write, pc_source, alu_src_a, alu_src_b, reg_write, state,
           alu_operation, alu_result, zero
  );
  modport slave (
    input  instruction_opcode, func3, func7, alu_in_x, alu_in_y,
    output pc_write, pc_write_cond, lord, memory_read, memory_write, memory_to_reg,
           ir_write, pc_source, alu_src_a, alu_src_b, reg_write, state,
           alu_operation, alu_result, zero
  );
endinterface

// File: rtl/rv_multicycle_ctrl_alu.sv
// rv_multicycle_ctrl_alu: Moore control FSM, ALU-op decoder and 32-bit ALU of the multicycle RV32I core
// clk/reset: clock and synchronous active-high reset
// bus (slave): opcode/func3/func7 and ALU operands in; mux selects, write enables, state, alu_operation, alu_result, zero out
module rv_multicycle_ctrl_alu (
  input logic                   clk,
  input logic                   reset,
  rv_multicycle_ctrl_alu_if.slave bus
);
  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    EXEC_I    = 4'd7,
    ALU_WB    = 4'd8,
    BRANCH    = 4'd9,
    JAL       = 4'd10,
    JALR      = 4'd11,
    LUI       = 4'd12
  } state_t;
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100, OP_SRL = 4'b0101, OP_SUB = 4'b0110, OP_SRA = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000, OP_SLTU = 4'b1001, OP_SGE = 4'b1010, OP_SGEU = 4'b1011;
  localparam logic [3:0] OP_SEQ = 4'b1100;
  state_t      cur, nxt;
  logic [1:0]  aluop;
  logic        is_immediate;
  logic        pcw, pcwc, irw, rw, mr, mw;
  logic [3:0]  op;
  logic [31:0] res;
  logic        f7_5;
  logic        unused_func7;
  assign f7_5 = bus.func7[5];
  assign unused_func7 = ^{bus.func7[6], bus.func7[4:0]};
  always_ff @(posedge clk)
    cur <= reset ? FETCH : nxt;
  always_comb begin
    nxt               = FETCH;
    pcw               = 1'b0;
    pcwc              = 1'b0;
    irw               = 1'b0;
    rw                = 1'b0;
    mr                = 1'b0;
    mw                = 1'b0;
    aluop             = 2'b00;
    is_immediate      = 1'b0;
    bus.lord          = 1'b0;
    bus.memory_to_reg = 1'b0;
    bus.pc_source     = 1'b0;
    bus.alu_src_a     = 2'b00;
    bus.alu_src_b     = 2'b00;
    case (cur)
      FETCH: begin
        mr            = 1'b1;
        irw           = 1'b1;
        pcw           = 1'b1;
        bus.alu_src_b = 2'b01;
        nxt           = DECODE;
      end
      DECODE: begin
        // ALU speculatively forms pc_old+imm for branch/jump targets
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b10;
        case (bus.instruction_opcode)
          7'b0000011, 7'b0100011: nxt = MEM_ADDR;
          7'b0110011:             nxt = EXEC_R;
          7'b0010011:             nxt = EXEC_I;
          7'b1100011:             nxt = BRANCH;
          7'b1101111:             nxt = JAL;
          7'b1100111:             nxt = JALR;
          7'b0110111:             nxt = LUI;
          7'b0010111:             nxt = ALU_WB;
          default:                nxt = FETCH;
        endcase
      end
      MEM_ADDR: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        nxt           = bus.instruction_opcode == 7'b0000011 ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        mr       = 1'b1;
        bus.lord = 1'b1;
        nxt      = MEM_WB;
      end
      MEM_WB: begin
        rw                = 1'b1;
        bus.memory_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        mw       = 1'b1;
        bus.lord = 1'b1;
      end
      EXEC_R: begin
        bus.alu_src_a = 2'b01;
        aluop         = 2'b10;
        nxt           = ALU_WB;
      end
      EXEC_I: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        aluop         = 2'b10;
        is_immediate  = 1'b1;
        nxt           = ALU_WB;
      end
      ALU_WB: rw = 1'b1;
      BRANCH: begin
        bus.alu_src_a = 2'b01;
        aluop         = 2'b01;
        pcwc          = 1'b1;
        bus.pc_source = 1'b1;
      end
      // JALR computes rs1+imm into ALUOut, then reuses JAL to load it and link
      JALR: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        nxt           = JAL;
      end
      // PC already holds pc_old+4, so PC+0 is the link value
      JAL: begin
        bus.alu_src_b = 2'b11;
        pcw           = 1'b1;
        bus.pc_source = 1'b1;
        nxt           = ALU_WB;
      end
      LUI: begin
        bus.alu_src_a = 2'b11;
        bus.alu_src_b = 2'b10;
        nxt           = ALU_WB;
      end
      default: nxt = FETCH;
    endcase
  end
  assign bus.pc_write      = pcw & ~reset;
  assign bus.pc_write_cond = pcwc & ~reset;
  assign bus.ir_write      = irw & ~reset;
  assign bus.reg_write     = rw & ~reset;
  assign bus.memory_read   = mr & ~reset;
  assign bus.memory_write  = mw & ~reset;
  assign bus.state         = cur;
  // branch ops are inverted so that a zero result means the branch is taken
  always_comb begin
    op = OP_ADD;
    if (aluop == 2'b01)
      case (bus.func3)
        3'b001:  op = OP_SEQ;
        3'b100:  op = OP_SGE;
        3'b101:  op = OP_SLT;
        3'b110:  op = OP_SGEU;
        3'b111:  op = OP_SLTU;
        default: op = OP_SUB;
      endcase
    else if (aluop == 2'b10)
      case (bus.func3)
        3'b000:  op = (!is_immediate && f7_5) ? OP_SUB : OP_ADD;
        3'b001:  op = OP_SLL;
        3'b010:  op = OP_SLT;
        3'b011:  op = OP_SLTU;
        3'b100:  op = OP_XOR;
        3'b101:  op = f7_5 ? OP_SRA : OP_SRL;
        3'b110:  op = OP_OR;
        default: op = OP_AND;
      endcase
  end
  assign bus.alu_operation = op;
  always_comb begin
    res = '0;
    case (op)
      OP_AND:  res = bus.alu_in_x & bus.alu_in_y;
      OP_OR:   res = bus.alu_in_x | bus.alu_in_y;
      OP_ADD:  res = bus.alu_in_x + bus.alu_in_y;
      OP_XOR:  res = bus.alu_in_x ^ bus.alu_in_y;
      OP_SUB:  res = bus.alu_in_x - bus.alu_in_y;
      OP_SLL:  res = bus.alu_in_x << bus.alu_in_y[4:0];
      OP_SRL:  res = bus.alu_in_x >> bus.alu_in_y[4:0];
      OP_SRA:  res = $signed(bus.alu_in_x) >>> bus.alu_in_y[4:0];
      OP_SLT:  res = {31'b0, $signed(bus.alu_in_x) < $signed(bus.alu_in_y)};
      OP_SLTU: res = {31'b0, bus.alu_in_x < bus.alu_in_y};
      OP_SGE:  res = {31'b0, $signed(bus.alu_in_x) >= $signed(bus.alu_in_y)};
      OP_SGEU: res = {31'b0, bus.alu_in_x >= bus.alu_in_y};
      OP_SEQ:  res = {31'b0, bus.alu_in_x == bus.alu_in_y};
      default: res = '0;
    endcase
  end
  assign bus.alu_result = res;
  assign bus.zero       = res == '0;
endmodule

// File: tb/tb_rv_multicycle_ctrl_alu.sv
// tb_rv_multicycle_ctrl_alu: directed self-checking bench for the control FSM, ALU decoder and ALU
module tb_rv_multicycle_ctrl_alu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  rv_multicycle_ctrl_alu_if bus();
  rv_multicycle_ctrl_alu dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    bus.instruction_opcode = 7'b0110011;
    bus.func3 = 3'b000;
    bus.func7 = 7'b0000000;
    bus.alu_in_x = 0;
    bus.alu_in_y = 0;
    reset = 1'b1;
    tick();
    tick();
    total++;
    if (bus.state !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", bus.state); end
    total++;
    if ({bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.reg_write, bus.memory_read, bus.memory_write} !== 6'b0) begin
      bad++; $display("FAIL reset_enables got=%b want=000000",
        {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.reg_write, bus.memory_read, bus.memory_write});
    end
    reset = 1'b0;
    #1;
    total++;
    if ({bus.pc_write, bus.ir_write, bus.memory_read, bus.lord, bus.pc_source, bus.alu_src_a, bus.alu_src_b} !== 9'b111000001) begin
      bad++; $display("FAIL fetch_ctrl got=%b want=111000001",
        {bus.pc_write, bus.ir_write, bus.memory_read, bus.lord, bus.pc_source, bus.alu_src_a, bus.alu_src_b});
    end
  endtask
  task automatic test_r_type();
    logic [3:0] exp [5] = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
    bus.instruction_opcode = 7'b0110011;
    bus.func3 = 3'b000;
    bus.func7 = 7'b0100000;
    bus.alu_in_x = 32'd5;
    bus.alu_in_y = 32'd7;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.state !== exp[i]) begin bad++; $display("FAIL r_state[%0d] got=%0d want=%0d", i, bus.state, exp[i]); end
      if (i == 2) begin
        total++;
        if (bus.alu_operation !== 4'b0110) begin bad++; $display("FAIL r_sub_op got=%b want=0110", bus.alu_operation); end
        total++;
        if (bus.alu_result !== 32'hFFFFFFFE) begin bad++; $display("FAIL r_sub_res got=%h want=fffffffe", bus.alu_result); end
        total++;
        if (bus.zero !== 1'b0) begin bad++; $display("FAIL r_sub_zero got=%b want=0", bus.zero); end
      end
      if (i == 3) begin
        total++;
        if ({bus.reg_write, bus.memory_to_reg} !== 2'b10) begin
          bad++; $display("FAIL alu_wb_ctrl got=%b want=10", {bus.reg_write, bus.memory_to_reg});
        end
      end
      if (i < 4) tick();
    end
  endtask
  task automatic test_r_ops();
    logic [2:0]  f3 [8] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b000};
    logic [31:0] xs [8] = '{32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000F0F0, 32'h80000000, 32'hF0, 32'hF0, 32'hFFFFFFFF};
    logic [31:0] ys [8] = '{32'h24, 32'd1, 32'd1, 32'h0000FF00, 32'd4, 32'h0F, 32'h3C, 32'd2};
    logic [3:0]  ops [8] = '{4'b0100, 4'b1000, 4'b1001, 4'b0011, 4'b0101, 4'b0001, 4'b0000, 4'b0010};
    logic [31:0] rs [8] = '{32'h30, 32'd1, 32'd0, 32'h00000FF0, 32'h08000000, 32'hFF, 32'h30, 32'd1};
    for (int k = 0; k < 8; k++) begin
      bus.instruction_opcode = 7'b0110011;
      bus.func3 = f3[k];
      bus.func7 = 7'b0000000;
      bus.alu_in_x = xs[k];
      bus.alu_in_y = ys[k];
      tick();
      tick();
      total++;
      if (bus.state !== 4'd6) begin bad++; $display("FAIL rop_state[%0d] got=%0d want=6", k, bus.state); end
      total++;
      if (bus.alu_operation !== ops[k]) begin bad++; $display("FAIL rop_op[%0d] got=%b want=%b", k, bus.alu_operation, ops[k]); end
      total++;
      if (bus.alu_result !== rs[k]) begin bad++; $display("FAIL rop_res[%0d] got=%h want=%h", k, bus.alu_result, rs[k]); end
      tick();
      tick();
    end
  endtask
  task automatic test_load();
    logic [3:0] exp [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    bus.instruction_opcode = 7'b0000011;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (bus.state !== exp[i]) begin bad++; $display("FAIL ld_state[%0d] got=%0d want=%0d", i, bus.state, exp[i]); end
      if (i == 2) begin
        total++;
        if ({bus.alu_src_a, bus.alu_src_b} !== 4'b0110) begin
          bad++; $display("FAIL mem_addr_sel got=%b want=0110", {bus.alu_src_a, bus.alu_src_b});
        end
      end
      if (i == 3) begin
        total++;
        if ({bus.memory_read, bus.lord, bus.reg_write} !== 3'b110) begin
          bad++; $display("FAIL mem_read_ctrl got=%b want=110", {bus.memory_read, bus.lord, bus.reg_write});
        end
      end
      if (i == 4) begin
        total++;
        if ({bus.reg_write, bus.memory_to_reg} !== 2'b11) begin
          bad++; $display("FAIL mem_wb_ctrl got=%b want=11", {bus.reg_write, bus.memory_to_reg});
        end
      end
      if (i < 5) tick();
    end
  endtask
  task automatic test_store();
    logic [3:0] exp [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    bus.instruction_opcode = 7'b0100011;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.state !== exp[i]) begin bad++; $display("FAIL st_state[%0d] got=%0d want=%0d", i, bus.state, exp[i]); end
      if (i == 3) begin
        total++;
        if ({bus.memory_write, bus.lord, bus.reg_write, bus.memory_read} !== 4'b1100) begin
          bad++; $display("FAIL mem_write_ctrl got=%b want=1100", {bus.memory_write, bus.lord, bus.reg_write, bus.memory_read});
        end
      end
      if (i < 4) tick();
    end
  endtask
  task automatic test_branch();
    logic [2:0]  f3 [6] = '{3'b100, 3'b110, 3'b000, 3'b001, 3'b101, 3'b111};
    logic [31:0] xs [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd9, 32'd9, 32'hFFFFFFFE, 32'd2};
    logic [31:0] ys [6] = '{32'd1, 32'd1, 32'd9, 32'd4, 32'd3, 32'hFFFFFFFF};
    logic [3:0]  ops [6] = '{4'b1010, 4'b1011, 4'b0110, 4'b1100, 4'b1000, 4'b1001};
    logic [31:0] rs [6] = '{32'd0, 32'd1, 32'd0, 32'd0, 32'd1, 32'd1};
    bus.instruction_opcode = 7'b1100011;
    bus.func7 = 7'b0000000;
    for (int k = 0; k < 6; k++) begin
      bus.func3 = f3[k];
      bus.alu_in_x = xs[k];
      bus.alu_in_y = ys[k];
      tick();
      tick();
      total++;
      if (bus.state !== 4'd9) begin bad++; $display("FAIL br_state[%0d] got=%0d want=9", k, bus.state); end
      total++;
      if (bus.alu_operation !== ops[k]) begin bad++; $display("FAIL br_op[%0d] got=%b want=%b", k, bus.alu_operation, ops[k]); end
      total++;
      if (bus.alu_result !== rs[k]) begin bad++; $display("FAIL br_res[%0d] got=%h want=%h", k, bus.alu_result, rs[k]); end
      total++;
      if (bus.zero !== (rs[k] == 32'd0)) begin bad++; $display("FAIL br_zero[%0d] got=%b want=%b", k, bus.zero, rs[k] == 32'd0); end
      total++;
      if ({bus.pc_write_cond, bus.pc_source, bus.pc_write, bus.alu_src_a, bus.alu_src_b} !== 7'b1100100) begin
        bad++; $display("FAIL br_ctrl[%0d] got=%b want=1100100", k,
          {bus.pc_write_cond, bus.pc_source, bus.pc_write, bus.alu_src_a, bus.alu_src_b});
      end
      tick();
      total++;
      if (bus.state !== 4'd0) begin bad++; $display("FAIL br_done[%0d] got=%0d want=0", k, bus.state); end
    end
  endtask
  task automatic test_exec_i();
    logic [3:0] exp [5] = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
    bus.instruction_opcode = 7'b0010011;
    bus.func3 = 3'b101;
    bus.func7 = 7'b0100000;
    bus.alu_in_x = 32'h80000000;
    bus.alu_in_y = 32'd4;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.state !== exp[i]) begin bad++; $display("FAIL i_state[%0d] got=%0d want=%0d", i, bus.state, exp[i]); end
      if (i == 2) begin
        total++;
        if (bus.alu_operation !== 4'b0111) begin bad++; $display("FAIL i_sra_op got=%b want=0111", bus.alu_operation); end
        total++;
        if (bus.alu_result !== 32'hF8000000) begin bad++; $display("FAIL i_sra_res got=%h want=f8000000", bus.alu_result); end
        total++;
        if ({bus.alu_src_a, bus.alu_src_b} !== 4'b0110) begin
          bad++; $display("FAIL i_sel got=%b want=0110", {bus.alu_src_a, bus.alu_src_b});
        end
      end
      if (i < 4) tick();
    end
    bus.func3 = 3'b000;
    bus.alu_in_x = 32'd3;
    bus.alu_in_y = 32'd4;
    tick();
    tick();
    total++;
    if (bus.alu_operation !== 4'b0010) begin bad++; $display("FAIL addi_op got=%b want=0010", bus.alu_operation); end
    total++;
    if (bus.alu_result !== 32'd7) begin bad++; $display("FAIL addi_res got=%h want=00000007", bus.alu_result); end
    tick();
    tick();
  endtask
  task automatic test_jumps();
    logic [3:0] exp [6] = '{4'd0, 4'd1, 4'd11, 4'd10, 4'd8, 4'd0};
    logic [3:0] jexp [5] = '{4'd0, 4'd1, 4'd10, 4'd8, 4'd0};
    bus.instruction_opcode = 7'b1100111;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (bus.state !== exp[i]) begin bad++; $display("FAIL jalr_state[%0d] got=%0d want=%0d", i, bus.state, exp[i]); end
      if (i == 1) begin
        total++;
        if ({bus.alu_src_a, bus.alu_src_b} !== 4'b1010) begin
          bad++; $display("FAIL decode_sel got=%b want=1010", {bus.alu_src_a, bus.alu_src_b});
        end
      end
      if (i == 2) begin
        total++;
        if ({bus.alu_src_a, bus.alu_src_b, bus.pc_write} !== 5'b01100) begin
          bad++; $display("FAIL jalr_ctrl got=%b want=01100", {bus.alu_src_a, bus.alu_src_b, bus.pc_write});
        end
      end
      if (i == 3) begin
        total++;
        if ({bus.pc_write, bus.pc_source, bus.alu_src_a, bus.alu_src_b, bus.reg_write} !== 7'b1100110) begin
          bad++; $display("FAIL jal_ctrl got=%b want=1100110",
            {bus.pc_write, bus.pc_source, bus.alu_src_a, bus.alu_src_b, bus.reg_write});
        end
      end
      if (i < 5) tick();
    end
    bus.instruction_opcode = 7'b1101111;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.state !== jexp[i]) begin bad++; $display("FAIL jal_state[%0d] got=%0d want=%0d", i, bus.state, jexp[i]); end
      if (i < 4) tick();
    end
  endtask
  task automatic test_lui_auipc();
    logic [3:0] lexp [5] = '{4'd0, 4'd1, 4'd12, 4'd8, 4'd0};
    logic [3:0] aexp [4] = '{4'd0, 4'd1, 4'd8, 4'd0};
    bus.instruction_opcode = 7'b0110111;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.state !== lexp[i]) begin bad++; $display("FAIL lui_state[%0d] got=%0d want=%0d", i, bus.state, lexp[i]); end
      if (i == 2) begin
        total++;
        if ({bus.alu_src_a, bus.alu_src_b, bus.alu_operation} !== 8'b11100010) begin
          bad++; $display("FAIL lui_ctrl got=%b want=11100010", {bus.alu_src_a, bus.alu_src_b, bus.alu_operation});
        end
      end
      if (i < 4) tick();
    end
    bus.instruction_opcode = 7'b0010111;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus.state !== aexp[i]) begin bad++; $display("FAIL auipc_state[%0d] got=%0d want=%0d", i, bus.state, aexp[i]); end
      if (i < 3) tick();
    end
  endtask
  task automatic test_reset_midflight();
    bus.instruction_opcode = 7'b0000011;
    tick();
    tick();
    tick();
    total++;
    if (bus.state !== 4'd3) begin bad++; $display("FAIL mid_pre_state got=%0d want=3", bus.state); end
    reset = 1'b1;
    #1;
    total++;
    if ({bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.reg_write, bus.memory_read, bus.memory_write} !== 6'b0) begin
      bad++; $display("FAIL mid_enables got=%b want=000000",
        {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.reg_write, bus.memory_read, bus.memory_write});
    end
    tick();
    total++;
    if (bus.state !== 4'd0) begin bad++; $display("FAIL mid_post_state got=%0d want=0", bus.state); end
    reset = 1'b0;
    #1;
    total++;
    if (bus.memory_read !== 1'b1) begin bad++; $display("FAIL mid_fetch_read got=%b want=1", bus.memory_read); end
  endtask
  task automatic test_illegal();
    bus.instruction_opcode = 7'b0000000;
    tick();
    total++;
    if (bus.state !== 4'd1) begin bad++; $display("FAIL ill_decode got=%0d want=1", bus.state); end
    total++;
    if ({bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.reg_write, bus.memory_read, bus.memory_write} !== 6'b0) begin
      bad++; $display("FAIL ill_enables got=%b want=000000",
        {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.reg_write, bus.memory_read, bus.memory_write});
    end
    tick();
    total++;
    if (bus.state !== 4'd0) begin bad++; $display("FAIL ill_back got=%0d want=0", bus.state); end
  endtask
  initial begin
    test_reset();
    test_r_type();
    test_r_ops();
    test_load();
    test_store();
    test_branch();
    test_exec_i();
    test_jumps();
    test_lui_auipc();
    test_reset_midflight();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
